// File: rtl/regfile_64x32.sv
// 32 x 64-bit register file for the ID stage: two combinational read ports,
// one WB write port, hardwired-zero entry, and same-cycle write-through bypass.
module regfile_64x32 #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [DEPTH_LOG2-1:0] WriteRegister,
  input  logic [WIDTH-1:0]      WriteData,
  input  logic [DEPTH_LOG2-1:0] ReadRegister1,
  input  logic [DEPTH_LOG2-1:0] ReadRegister2,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2
);

  localparam int unsigned NUM_REGS = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] ZERO_IDX = DEPTH_LOG2'(ZERO_REG);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;
  logic                bypass1;
  logic                bypass2;

  // One-hot write enable; the zero register's decode is tied off.
  always_comb begin
    wr_en = '0;
    if (RegWrite) begin
      wr_en[WriteRegister] = 1'b1;
    end
    wr_en[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (wr_en[i]) begin
        regs[i] <= WriteData;
      end
    end
  end

  // Forward the WB value so a same-cycle read sees it before the edge.
  always_comb begin
    bypass1 = RegWrite && !reset && (WriteRegister == ReadRegister1)
              && (ReadRegister1 != ZERO_IDX);
    bypass2 = RegWrite && !reset && (WriteRegister == ReadRegister2)
              && (ReadRegister2 != ZERO_IDX);
  end

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadRegister1 != ZERO_IDX) begin
      ReadData1 = bypass1 ? WriteData : regs[ReadRegister1];
    end
    if (ReadRegister2 != ZERO_IDX) begin
      ReadData2 = bypass2 ? WriteData : regs[ReadRegister2];
    end
  end

endmodule
